// File: rtl/ram_port_arb.sv
// Round-robin arbiter sharing one byte-writable synchronous RAM port between REQ_NUM requesters.
// Define RAM_PORT_ARB_STRICT_PRIO_EN for fixed priority (lowest index wins, no rotating pointer).
`timescale 1ns/1ps
module ram_port_arb #(
  parameter int REQ_NUM    = 4,
  parameter int MEM_DEPTH  = 1024,
  parameter int BYTE_WIDTH = 8,
  parameter int BYTE_NUM   = 4,
  parameter int RD_LATENCY = 1,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int MEM_WIDTH  = BYTE_WIDTH * BYTE_NUM,
  parameter int ID_WIDTH   = $clog2(REQ_NUM)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [REQ_NUM-1:0]                   req_valid_i,
  output logic [REQ_NUM-1:0]                   req_ready_o,
  input  logic [REQ_NUM-1:0][BYTE_NUM-1:0]     req_wr_en_i,
  input  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [REQ_NUM-1:0][MEM_WIDTH-1:0]    req_data_i,
  output logic [REQ_NUM-1:0]                   rsp_valid_o,
  output logic [MEM_WIDTH-1:0]                 rsp_data_o,
  output logic                                 ram_en_o,
  output logic [BYTE_NUM-1:0]                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0]                ram_addr_o,
  output logic [MEM_WIDTH-1:0]                 ram_data_o,
  input  logic [MEM_WIDTH-1:0]                 ram_data_i
);

  logic [ID_WIDTH-1:0]   w_start;
  logic [ID_WIDTH-1:0]   w_cand;
  logic [ID_WIDTH-1:0]   w_win_id;
  logic                  w_found;
  logic                  w_gnt;
  logic                  w_rd;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic [MEM_WIDTH-1:0]  r_data_hold;

  logic [RD_LATENCY-1:0]               r_tag_vld_p;
  logic [RD_LATENCY-1:0][ID_WIDTH-1:0] r_tag_id_p;

`ifdef RAM_PORT_ARB_STRICT_PRIO_EN
  assign w_start = '0;
`else
  logic [ID_WIDTH-1:0] r_prio_ptr;

  assign w_start = r_prio_ptr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prio_ptr <= '0;
    end else if (w_gnt) begin
      r_prio_ptr <= (w_win_id == ID_WIDTH'(REQ_NUM - 1)) ? '0 : w_win_id + 1'b1;
    end
  end
`endif

  // Search upward from the start index, wrapping modulo REQ_NUM.
  always_comb begin
    w_found  = 1'b0;
    w_win_id = '0;
    w_cand   = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      w_cand = ID_WIDTH'((int'(w_start) + i) % REQ_NUM);
      if (!w_found && req_valid_i[w_cand]) begin
        w_found  = 1'b1;
        w_win_id = w_cand;
      end
    end
  end

  assign w_gnt = w_found & ~rst_i;
  assign w_rd  = w_gnt & ~(|req_wr_en_i[w_win_id]);

  always_comb begin
    req_ready_o = '0;
    if (w_gnt) req_ready_o[w_win_id] = 1'b1;
  end

  assign ram_en_o    = (|req_valid_i) & ~rst_i;
  assign ram_wr_en_o = w_gnt ? req_wr_en_i[w_win_id] : '0;
  assign ram_addr_o  = rst_i ? '0 : (w_gnt ? req_addr_i[w_win_id] : r_addr_hold);
  assign ram_data_o  = rst_i ? '0 : (w_gnt ? req_data_i[w_win_id] : r_data_hold);

  // Idle cycles replay the last granted address/data to avoid needless RAM port toggling.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr_hold <= '0;
      r_data_hold <= '0;
    end else if (w_gnt) begin
      r_addr_hold <= req_addr_i[w_win_id];
      r_data_hold <= req_data_i[w_win_id];
    end
  end

  // Tag pipeline p0..pN: valid is control (reset), id is data (no reset).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tag_vld_p <= '0;
    end else begin
      r_tag_vld_p[0] <= w_rd;
      for (int i = 1; i < RD_LATENCY; i++) r_tag_vld_p[i] <= r_tag_vld_p[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    r_tag_id_p[0] <= w_win_id;
    for (int i = 1; i < RD_LATENCY; i++) r_tag_id_p[i] <= r_tag_id_p[i-1];
  end

  // Last tag stage lines up with ram_data_i; route the strobe to the issuing requester.
  always_comb begin
    rsp_valid_o = '0;
    if (r_tag_vld_p[RD_LATENCY-1] && !rst_i) rsp_valid_o[r_tag_id_p[RD_LATENCY-1]] = 1'b1;
  end

  assign rsp_data_o = ram_data_i;

endmodule

// File: tb/tb_ram_port_arb.sv
// Bench for ram_port_arb: two instances (read latency 3 and 1) share stimulus; scoreboards check returns.
`timescale 1ns/1ps
module tb_ram_port_arb;
  localparam int RN = 4;
  localparam int BN = 4;
  localparam int AW = 10;
  localparam int MW = 32;
  localparam int LA = 3;
  localparam int LB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [RN-1:0]          valid;
  logic [RN-1:0][BN-1:0]  wr;
  logic [RN-1:0][AW-1:0]  addr;
  logic [RN-1:0][MW-1:0]  data;

  logic [RN-1:0] rdy_a, rsp_v_a, rdy_b, rsp_v_b;
  logic [MW-1:0] rsp_d_a, rsp_d_b, rdat_a, rdat_b, rin_a, rin_b;
  logic          en_a, en_b;
  logic [BN-1:0] wen_a, wen_b;
  logic [AW-1:0] raddr_a, raddr_b;

  ram_port_arb #(.REQ_NUM(RN), .MEM_DEPTH(1024), .BYTE_WIDTH(8), .BYTE_NUM(BN), .RD_LATENCY(LA)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(rdy_a), .req_wr_en_i(wr),
    .req_addr_i(addr), .req_data_i(data), .rsp_valid_o(rsp_v_a), .rsp_data_o(rsp_d_a),
    .ram_en_o(en_a), .ram_wr_en_o(wen_a), .ram_addr_o(raddr_a), .ram_data_o(rdat_a), .ram_data_i(rin_a));

  ram_port_arb #(.REQ_NUM(RN), .MEM_DEPTH(1024), .BYTE_WIDTH(8), .BYTE_NUM(BN), .RD_LATENCY(LB)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(rdy_b), .req_wr_en_i(wr),
    .req_addr_i(addr), .req_data_i(data), .rsp_valid_o(rsp_v_b), .rsp_data_o(rsp_d_b),
    .ram_en_o(en_b), .ram_wr_en_o(wen_b), .ram_addr_o(raddr_b), .ram_data_o(rdat_b), .ram_data_i(rin_b));

  function automatic logic [31:0] init_word(int i);
    return (i == 5) ? 32'h11223344 : (32'hA5000000 | 32'(i));
  endfunction

  // RAM models
  logic        load;
  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];
  logic [31:0] pipe_a [LA];
  logic [31:0] pipe_b [LB];
  assign rin_a = pipe_a[LA-1];
  assign rin_b = pipe_b[LB-1];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 1024; i++) mem_a[i] <= init_word(i);
    end else if (en_a) begin
      for (int b = 0; b < BN; b++) if (wen_a[b]) mem_a[raddr_a][b*8 +: 8] <= rdat_a[b*8 +: 8];
    end
    pipe_a[0] <= mem_a[raddr_a];
    for (int k = 1; k < LA; k++) pipe_a[k] <= pipe_a[k-1];
  end

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 1024; i++) mem_b[i] <= init_word(i);
    end else if (en_b) begin
      for (int b = 0; b < BN; b++) if (wen_b[b]) mem_b[raddr_b][b*8 +: 8] <= rdat_b[b*8 +: 8];
    end
    pipe_b[0] <= mem_b[raddr_b];
    for (int k = 1; k < LB; k++) pipe_b[k] <= pipe_b[k-1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic                  rst;
    logic [RN-1:0]         valid;
    logic [RN-1:0][BN-1:0] wr;
    logic [RN-1:0][AW-1:0] addr;
    logic [RN-1:0][MW-1:0] data;
    logic [RN-1:0]         exp_rdy;
  } vec_t;

  typedef struct {
    int          due;
    logic [3:0]  id1h;
    logic [31:0] dat;
  } sb_t;

  vec_t        tbl[$];
  sb_t         qa[$];
  sb_t         qb[$];
  logic [31:0] shadow [1024];
  logic [AW-1:0] last_addr;
  logic [MW-1:0] last_data;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic rs, input logic [3:0] v, input logic [3:0] exp,
                              input int r = 4, input logic [3:0] w = 4'h0,
                              input logic [9:0] a = 10'h0, input logic [31:0] d = 32'h0);
    vec_t t;
    t.rst = rs; t.valid = v; t.exp_rdy = exp;
    for (int i = 0; i < RN; i++) begin
      t.wr[i]   = 4'h0;
      t.addr[i] = 10'(10 + i);
      t.data[i] = 32'h5A5A0000 | 32'(i);
    end
    if (r < RN) begin
      t.wr[r] = w; t.addr[r] = a; t.data[r] = d;
    end
    return t;
  endfunction

  task automatic step(input vec_t t);
    int win;
    @(posedge clk);
    #1;
    rst = t.rst; valid = t.valid; wr = t.wr; addr = t.addr; data = t.data;
    if (t.rst) begin
      qa.delete();
      qb.delete();
    end
    @(negedge clk);
    win = -1;
    for (int i = 0; i < RN; i++) if (t.exp_rdy[i]) win = i;
    chk("ready_a", 64'(rdy_a), 64'(t.exp_rdy));
    chk("ready_b", 64'(rdy_b), 64'(t.exp_rdy));
    chk("ram_en", 64'(en_a), 64'((|t.valid) && !t.rst));
    if (win >= 0) begin
      chk("ram_wr_en", 64'(wen_a), 64'(t.wr[win]));
      chk("ram_addr", 64'(raddr_a), 64'(t.addr[win]));
      chk("ram_data", 64'(rdat_a), 64'(t.data[win]));
    end else begin
      chk("ram_wr_en_idle", 64'(wen_a), 64'h0);
      chk("ram_addr_hold", 64'(raddr_a), t.rst ? 64'h0 : 64'(last_addr));
      chk("ram_data_hold", 64'(rdat_a), t.rst ? 64'h0 : 64'(last_data));
    end
    if (qa.size() > 0 && qa[0].due == cyc) begin
      chk("rsp_valid_a", 64'(rsp_v_a), 64'(qa[0].id1h));
      chk("rsp_data_a", 64'(rsp_d_a), 64'(qa[0].dat));
      void'(qa.pop_front());
    end else begin
      chk("rsp_quiet_a", 64'(rsp_v_a), 64'h0);
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      chk("rsp_valid_b", 64'(rsp_v_b), 64'(qb[0].id1h));
      chk("rsp_data_b", 64'(rsp_d_b), 64'(qb[0].dat));
      void'(qb.pop_front());
    end else begin
      chk("rsp_quiet_b", 64'(rsp_v_b), 64'h0);
    end
    if (t.rst) begin
      last_addr = '0;
      last_data = '0;
    end else if (win >= 0) begin
      last_addr = t.addr[win];
      last_data = t.data[win];
      if (t.wr[win] == 4'h0) begin
        qa.push_back('{due: cyc + LA, id1h: t.exp_rdy, dat: shadow[t.addr[win]]});
        qb.push_back('{due: cyc + LB, id1h: t.exp_rdy, dat: shadow[t.addr[win]]});
      end else begin
        for (int b = 0; b < BN; b++)
          if (t.wr[win][b]) shadow[t.addr[win]][b*8 +: 8] = t.data[win][b*8 +: 8];
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; load = 1'b1; valid = '0; wr = '0; addr = '0; data = '0;
    last_addr = '0; last_data = '0;
    for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);

    tbl.push_back(mk(1'b1, 4'b0000, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b0000));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000));
`ifdef RAM_PORT_ARB_STRICT_PRIO_EN
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b0, 4'b0101, 4'b0001));
    tbl.push_back(mk(1'b0, 4'b0100, 4'b0100));
`else
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1'b0, 4'b1111, 4'(1 << (i % 4))));
`endif
    // partial-mask write then read-back by another requester
    tbl.push_back(mk(1'b0, 4'b0100, 4'b0100, 2, 4'b0011, 10'd5, 32'hDEADBEEF));
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0010, 1, 4'b0000, 10'd5));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000));
    tbl.push_back(mk(1'b0, 4'b0001, 4'b0001));
    tbl.push_back(mk(1'b0, 4'b1000, 4'b1000));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000));
`ifdef RAM_PORT_ARB_STRICT_PRIO_EN
    tbl.push_back(mk(1'b0, 4'b0011, 4'b0001, 1, 4'b1111, 10'd20, 32'hCAFEF00D));
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0010, 1, 4'b1111, 10'd20, 32'hCAFEF00D));
    tbl.push_back(mk(1'b0, 4'b0011, 4'b0001, 1, 4'b0000, 10'd20));
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0010, 1, 4'b0000, 10'd20));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 4'b1101, 4'b0001));
`else
    tbl.push_back(mk(1'b0, 4'b0011, 4'b0001, 1, 4'b1111, 10'd20, 32'hCAFEF00D));
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0010, 1, 4'b1111, 10'd20, 32'hCAFEF00D));
    tbl.push_back(mk(1'b0, 4'b0001, 4'b0001));
    tbl.push_back(mk(1'b0, 4'b0011, 4'b0010, 1, 4'b0000, 10'd20));
    tbl.push_back(mk(1'b0, 4'b0001, 4'b0001));
    tbl.push_back(mk(1'b0, 4'b1101, 4'b0100));
    tbl.push_back(mk(1'b0, 4'b1101, 4'b1000));
    tbl.push_back(mk(1'b0, 4'b1101, 4'b0001));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
      if (i == 0) load = 1'b0;
    end

    // Reset while a read is in flight: no late strobe, pointer back to 0.
    step(mk(1'b0, 4'b0100, 4'b0100, 2, 4'b0000, 10'd7));
    step(mk(1'b1, 4'b1111, 4'b0000));
    step(mk(1'b1, 4'b1111, 4'b0000));
    step(mk(1'b0, 4'b1111, 4'b0001));
    step(mk(1'b0, 4'b0000, 4'b0000));

    for (int i = 0; i < 6; i++) step(mk(1'b0, 4'b0000, 4'b0000));
    chk("sb_drain_a", 64'(qa.size()), 64'h0);
    chk("sb_drain_b", 64'(qb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
